// File: rtl/ht_pair_decoder.sv
// Bit-serial MP3 Huffman big_values pair decoder with an external codebook lookup.
// Optional HT_BITCOUNT_EN adds a saturating consumed-bit counter on bits_used.
module ht_pair_decoder #(
  parameter int unsigned MAX_BITS = 19,
  parameter int unsigned MAXLIN   = 13,
  parameter int unsigned VAL_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          linbits,
  input  logic [9:0]          pair_count,
  input  logic                axiiv,
  input  logic                axiid,
  output logic                axiir,
  output logic [4:0]          lut_len,
  output logic [MAX_BITS-1:0] lut_bits,
  input  logic                lut_hit,
  input  logic [3:0]          lut_x,
  input  logic [3:0]          lut_y,
  output logic                axiov,
  input  logic                axior,
  output logic [VAL_W-1:0]    x_val,
  output logic [VAL_W-1:0]    y_val,
  output logic                done,
  output logic                err,
  output logic [15:0]         bits_used
);

  localparam int unsigned LEN_W = 5;
  localparam int unsigned LB_W  = 4;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [3:0] {
    S_IDLE, S_CODE, S_XLIN, S_XSGN, S_YLIN, S_YSGN, S_OUT, S_DONE, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [LB_W-1:0]     lin_q, lin_d;
  logic [LB_W-1:0]     lin_cnt_q, lin_cnt_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]    pair_cnt_q, pair_cnt_d;
  logic [LEN_W-1:0]    lut_len_q, lut_len_d;
  logic [MAX_BITS-1:0] lut_bits_q, lut_bits_d;
  logic [3:0]          x_abs_q, x_abs_d, y_abs_q, y_abs_d;
  logic [MAXLIN-1:0]   x_lin_q, x_lin_d, y_lin_q, y_lin_d;
  logic                x_neg_q, x_neg_d, y_neg_q, y_neg_d;
  logic                err_q, err_d, done_q, done_d, axiov_q, axiov_d;
  logic [VAL_W-1:0]    x_val_q, x_val_d, y_val_q, y_val_d;
  logic                axiir_c;

  // After the x fields: decide which y field (if any) is needed next.
  function automatic state_t after_x(input logic [3:0] ya, input logic [LB_W-1:0] lb);
    if (ya == 4'd15 && lb != '0) return S_YLIN;
    else if (ya != 4'd0)         return S_YSGN;
    else                         return S_OUT;
  endfunction

  function automatic logic [VAL_W-1:0] signed_mag(input logic [3:0] a,
                                                  input logic [MAXLIN-1:0] l,
                                                  input logic neg);
    logic [VAL_W-1:0] m;
    m = VAL_W'(a) + VAL_W'(l);
    return neg ? -m : m;
  endfunction

  always_comb begin
    state_d    = state_q;
    lin_d      = lin_q;
    lin_cnt_d  = lin_cnt_q;
    target_d   = target_q;
    pair_cnt_d = pair_cnt_q;
    lut_len_d  = lut_len_q;
    lut_bits_d = lut_bits_q;
    x_abs_d    = x_abs_q;
    y_abs_d    = y_abs_q;
    x_lin_d    = x_lin_q;
    y_lin_d    = y_lin_q;
    x_neg_d    = x_neg_q;
    y_neg_d    = y_neg_q;
    err_d      = err_q;
    x_val_d    = x_val_q;
    y_val_d    = y_val_q;
    axiir_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lin_d      = (linbits > LB_W'(MAXLIN)) ? LB_W'(MAXLIN) : linbits;
          target_d   = pair_count;
          pair_cnt_d = '0;
          err_d      = 1'b0;
          lut_len_d  = '0;
          lut_bits_d = '0;
          lin_cnt_d  = '0;
          x_lin_d    = '0;
          y_lin_d    = '0;
          x_neg_d    = 1'b0;
          y_neg_d    = 1'b0;
          state_d    = (pair_count == '0) ? S_DONE : S_CODE;
        end
      end
      S_CODE: begin
        if (lut_len_q != '0 && lut_hit) begin
          x_abs_d    = lut_x;
          y_abs_d    = lut_y;
          lut_len_d  = '0;
          lut_bits_d = '0;
          lin_cnt_d  = '0;
          if (lut_x == 4'd15 && lin_q != '0) state_d = S_XLIN;
          else if (lut_x != 4'd0)            state_d = S_XSGN;
          else                               state_d = after_x(lut_y, lin_q);
        end else if (lut_len_q == LEN_W'(MAX_BITS)) begin
          state_d = S_ERR;
        end else begin
          axiir_c = 1'b1;
          if (axiiv) begin
            lut_bits_d = {lut_bits_q[MAX_BITS-2:0], axiid};
            lut_len_d  = lut_len_q + LEN_W'(1);
          end
        end
      end
      S_XLIN: begin
        axiir_c = 1'b1;
        if (axiiv) begin
          x_lin_d = {x_lin_q[MAXLIN-2:0], axiid};
          if (lin_cnt_q == lin_q - LB_W'(1)) begin
            lin_cnt_d = '0;
            state_d   = S_XSGN;
          end else begin
            lin_cnt_d = lin_cnt_q + LB_W'(1);
          end
        end
      end
      S_XSGN: begin
        axiir_c = 1'b1;
        if (axiiv) begin
          x_neg_d = axiid;
          state_d = after_x(y_abs_q, lin_q);
        end
      end
      S_YLIN: begin
        axiir_c = 1'b1;
        if (axiiv) begin
          y_lin_d = {y_lin_q[MAXLIN-2:0], axiid};
          if (lin_cnt_q == lin_q - LB_W'(1)) begin
            lin_cnt_d = '0;
            state_d   = S_YSGN;
          end else begin
            lin_cnt_d = lin_cnt_q + LB_W'(1);
          end
        end
      end
      S_YSGN: begin
        axiir_c = 1'b1;
        if (axiiv) begin
          y_neg_d = axiid;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (axior) begin
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
          x_lin_d    = '0;
          y_lin_d    = '0;
          x_neg_d    = 1'b0;
          y_neg_d    = 1'b0;
          state_d    = (pair_cnt_d == target_q) ? S_DONE : S_CODE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        err_d      = 1'b1;
        lut_len_d  = '0;
        lut_bits_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Output values are captured once on entry to OUT and held through the stall.
    if (state_d == S_OUT && state_q != S_OUT) begin
      x_val_d = signed_mag(x_abs_d, x_lin_d, x_neg_d);
      y_val_d = signed_mag(y_abs_d, y_lin_d, y_neg_d);
    end
  end

  assign axiov_d = (state_d == S_OUT);
  assign done_d  = (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lin_q      <= '0;
      lin_cnt_q  <= '0;
      target_q   <= '0;
      pair_cnt_q <= '0;
      lut_len_q  <= '0;
      lut_bits_q <= '0;
      x_abs_q    <= '0;
      y_abs_q    <= '0;
      x_lin_q    <= '0;
      y_lin_q    <= '0;
      x_neg_q    <= 1'b0;
      y_neg_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      axiov_q    <= 1'b0;
      x_val_q    <= '0;
      y_val_q    <= '0;
    end else begin
      state_q    <= state_d;
      lin_q      <= lin_d;
      lin_cnt_q  <= lin_cnt_d;
      target_q   <= target_d;
      pair_cnt_q <= pair_cnt_d;
      lut_len_q  <= lut_len_d;
      lut_bits_q <= lut_bits_d;
      x_abs_q    <= x_abs_d;
      y_abs_q    <= y_abs_d;
      x_lin_q    <= x_lin_d;
      y_lin_q    <= y_lin_d;
      x_neg_q    <= x_neg_d;
      y_neg_q    <= y_neg_d;
      err_q      <= err_d;
      done_q     <= done_d;
      axiov_q    <= axiov_d;
      x_val_q    <= x_val_d;
      y_val_q    <= y_val_d;
    end
  end

`ifdef HT_BITCOUNT_EN
  logic [15:0] bits_q, bits_d;

  // Saturating count of consumed bits since the last accepted start.
  always_comb begin
    bits_d = bits_q;
    if (state_q == S_IDLE && start)
      bits_d = '0;
    else if (axiiv && axiir_c && bits_q != 16'hFFFF)
      bits_d = bits_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits_q <= '0;
    else     bits_q <= bits_d;
  end

  assign bits_used = bits_q;
`else
  assign bits_used = '0;
`endif

  assign axiir    = axiir_c;
  assign lut_len  = lut_len_q;
  assign lut_bits = lut_bits_q;
  assign axiov    = axiov_q;
  assign x_val    = x_val_q;
  assign y_val    = y_val_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ht_pair_decoder.sv
// Scoreboard bench for ht_pair_decoder with a small five-entry codebook model.
module tb_ht_pair_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  linbits;
  logic [9:0]  pair_count;
  logic        axiiv, axiid, axiir;
  logic [4:0]  lut_len;
  logic [18:0] lut_bits;
  logic        lut_hit;
  logic [3:0]  lut_x, lut_y;
  logic        axiov, axior;
  logic [15:0] x_val, y_val;
  logic        done, err;
  logic [15:0] bits_used;

  logic        force_miss;
  int          vectors = 0;
  int          miscompares = 0;
  int          tb_bits = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } pair_t;
  pair_t exp_q[$];
  pair_t mon_e;

  always #5 clk = ~clk;

  ht_pair_decoder dut (
    .clk(clk), .rst(rst), .start(start), .linbits(linbits), .pair_count(pair_count),
    .axiiv(axiiv), .axiid(axiid), .axiir(axiir), .lut_len(lut_len), .lut_bits(lut_bits),
    .lut_hit(lut_hit), .lut_x(lut_x), .lut_y(lut_y), .axiov(axiov), .axior(axior),
    .x_val(x_val), .y_val(y_val), .done(done), .err(err), .bits_used(bits_used)
  );

  // Codebook: 1->(0,0) 010->(0,1) 011->(1,0) 001->(1,1) 000->(15,15).
  always_comb begin
    lut_hit = 1'b0;
    lut_x   = 4'd0;
    lut_y   = 4'd0;
    if (!force_miss) begin
      if (lut_len == 5'd1 && lut_bits[0]) begin
        lut_hit = 1'b1;
      end else if (lut_len == 5'd3) begin
        case (lut_bits[2:0])
          3'b010: begin lut_hit = 1'b1; lut_y = 4'd1; end
          3'b011: begin lut_hit = 1'b1; lut_x = 4'd1; end
          3'b001: begin lut_hit = 1'b1; lut_x = 4'd1; lut_y = 4'd1; end
          3'b000: begin lut_hit = 1'b1; lut_x = 4'd15; lut_y = 4'd15; end
          default: lut_hit = 1'b0;
        endcase
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: pop on every handshake.
  always @(negedge clk) begin
    #2;
    if (!rst && axiov && axior) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pair", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("x_val", 32'(x_val), 32'(mon_e.x));
        check_val("y_val", 32'(y_val), 32'(mon_e.y));
      end
    end
  end

  task automatic run(input logic [3:0] lb, input logic [9:0] cnt);
    @(negedge clk);
    start = 1'b1; linbits = lb; pair_count = cnt;
    tb_bits = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] b, input int n);
    logic ok;
    for (int i = n - 1; i >= 0; i--) begin
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        axiiv = 1'b1;
        axiid = b[i];
        #1 ok = axiir;
        @(posedge clk);
      end
      if (!ok) check_val("send_timeout", 32'd0, 32'd1);
      else     tb_bits++;
    end
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < budget && !seen; t++) begin
      @(negedge clk);
      #1 seen = done;
    end
    check_val("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    check_val("done_width", 32'(done), 32'd0);
    check_val("idle_axiir", 32'(axiir), 32'd0);
  endtask

  task automatic check_bits(input string tag);
`ifdef HT_BITCOUNT_EN
    check_val(tag, 32'(bits_used), 32'(tb_bits));
`else
    check_val(tag, 32'(bits_used), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; linbits = '0; pair_count = '0;
    axiiv = 1'b0; axiid = 1'b0; axior = 1'b1; force_miss = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_axiir", 32'(axiir), 32'd0);
    check_val("rst_axiov", 32'(axiov), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_xy", {x_val, y_val}, 32'd0);
    check_val("rst_lut", {8'(lut_len), 24'(lut_bits)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single (0,0) from one bit
    run(4'd0, 10'd1);
    exp_q.push_back('{16'd0, 16'd0});
    send_bits(32'b1, 1);
    wait_done(20);
    check_bits("bits_s1");

    // 2: two pairs with sign bits
    run(4'd0, 10'd2);
    exp_q.push_back('{16'd0, 16'hFFFF});
    exp_q.push_back('{16'd1, 16'd0});
    send_bits(32'b0101_0110, 8);
    wait_done(20);

    // 3: escape values with linbits=4
    run(4'd4, 10'd1);
    exp_q.push_back('{16'd18, 16'hFFE7});
    send_bits(32'b000_0011_0_1010_1, 13);
    wait_done(20);
    check_bits("bits_s3");
    check_val("tb_bits_s3", 32'(tb_bits), 32'd13);

    // 4: downstream stall holds the pair and consumes nothing
    run(4'd0, 10'd1);
    axior = 1'b0;
    exp_q.push_back('{16'hFFFF, 16'd1});
    send_bits(32'b00110, 5);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      #1 seen = axiov;
    end
    check_val("stall_axiov_seen", 32'(seen), 32'd1);
    axiiv = 1'b1;
    axiid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      check_val("stall_axiov", 32'(axiov), 32'd1);
      check_val("stall_xy", {x_val, y_val}, {16'hFFFF, 16'd1});
      check_val("stall_axiir", 32'(axiir), 32'd0);
      check_val("stall_lut_len", 32'(lut_len), 32'd0);
    end
    check_bits("bits_stall");
    axiiv = 1'b0;
    axior = 1'b1;
    wait_done(20);

    // 5: codeword overflow, then err clears on the next start
    force_miss = 1'b1;
    run(4'd0, 10'd1);
    send_bits(32'h7FFFF, 19);
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      #1 seen = err;
    end
    check_val("err_set", 32'(seen), 32'd1);
    check_val("err_tb_bits", 32'(tb_bits), 32'd19);
    check_bits("bits_err");
    @(negedge clk);
    #1;
    check_val("err_sticky", 32'(err), 32'd1);
    check_val("err_idle_axiir", 32'(axiir), 32'd0);
    check_val("err_lut_len", 32'(lut_len), 32'd0);
    force_miss = 1'b0;
    run(4'd0, 10'd1);
    #1;
    check_val("err_cleared", 32'(err), 32'd0);
    exp_q.push_back('{16'd0, 16'd0});
    send_bits(32'b1, 1);
    wait_done(20);

    // 6: reset in the middle of XLIN
    run(4'd4, 10'd1);
    send_bits(32'b000_00, 5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_axiir", 32'(axiir), 32'd0);
    check_val("midrst_axiov_done_err", {29'd0, axiov, done, err}, 32'd0);
    check_val("midrst_xy", {x_val, y_val}, 32'd0);
    check_val("midrst_lut", {8'(lut_len), 24'(lut_bits)}, 32'd0);
    check_val("midrst_bits", 32'(bits_used), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
